// File: rtl/trap_if.sv
// Trap controller bus: fault/irq sources and the fetch-side redirect outputs.
// The master drives the sources; the slave (trap_controller) drives the redirects.
interface trap_if #(
   parameter int ADDR_W  = 19,
   parameter int NUM_IRQ = 4
);
   logic               stall;
   logic               illegal_instr;
   logic               syscall;
   logic               arith_ovf;
   logic               eret;
   logic [NUM_IRQ-1:0] irq;
   logic               mask_we;
   logic [NUM_IRQ-1:0] mask_wdata;
   logic [ADDR_W-1:0]  epc_in;
   logic               exception;
   logic [ADDR_W-1:0]  handler_address;
   logic               ret_taken;
   logic [ADDR_W-1:0]  ret_target;
   logic [3:0]         cause;
   logic               in_handler;
   logic [NUM_IRQ-1:0] irq_ack;
   logic               double_fault;

   modport master (
      output stall, illegal_instr, syscall, arith_ovf, eret, irq, mask_we, mask_wdata, epc_in,
      input  exception, handler_address, ret_taken, ret_target, cause, in_handler, irq_ack,
             double_fault
   );
   modport slave (
      input  stall, illegal_instr, syscall, arith_ovf, eret, irq, mask_we, mask_wdata, epc_in,
      output exception, handler_address, ret_taken, ret_target, cause, in_handler, irq_ack,
             double_fault
   );
endinterface

// File: rtl/trap_controller.sv
// Exception/interrupt controller: prioritises faults and masked irqs, raises the
// trap redirect to fetch, saves the EPC, and redirects back on eret.
module trap_controller #(
   parameter int                ADDR_W   = 19,
   parameter int                NUM_IRQ  = 4,
   parameter logic [ADDR_W-1:0] VEC_BASE = 19'h7F000
) (
   input logic   clk,
   input logic   rst,
   trap_if.slave if_trap
);
   typedef enum logic [1:0] {S_RUN, S_ENTER, S_HANDLER, S_RETURN} state_t;

   state_t             r_state, w_next;
   logic [3:0]         r_cause;
   logic [ADDR_W-1:0]  r_haddr;
   logic [ADDR_W-1:0]  r_epc;
   logic [NUM_IRQ-1:0] r_mask;
   logic [NUM_IRQ-1:0] r_irq_ack;
   logic               r_first;
   logic               r_df;

   logic               w_sync;
   logic [NUM_IRQ-1:0] w_pend;
   logic [3:0]         w_cause;
   logic [ADDR_W-1:0]  w_vec;

   assign w_sync = if_trap.illegal_instr | if_trap.syscall | if_trap.arith_ovf;
   assign w_pend = if_trap.irq & r_mask;

   // Lower irq index wins, so scan downward and let the last hit stand.
   always_comb begin
      w_cause = 4'd0;
      if (if_trap.illegal_instr)  w_cause = 4'd1;
      else if (if_trap.syscall)   w_cause = 4'd2;
      else if (if_trap.arith_ovf) w_cause = 4'd3;
      else begin
         for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (w_pend[i]) w_cause = 4'(8 + i);
      end
   end

   assign w_vec = VEC_BASE + ADDR_W'({w_cause, 2'b00});

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RUN:     if ((w_sync || (|w_pend)) && !if_trap.stall) w_next = S_ENTER;
         S_ENTER:   if (!if_trap.stall) w_next = S_HANDLER;
         S_HANDLER: if (if_trap.eret && !if_trap.stall) w_next = S_RETURN;
         S_RETURN:  if (!if_trap.stall) w_next = S_RUN;
         default:   w_next = S_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_RUN;
         r_cause   <= '0;
         r_haddr   <= '0;
         r_epc     <= '0;
         r_mask    <= '0;
         r_irq_ack <= '0;
         r_first   <= 1'b0;
         r_df      <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_RUN && w_next == S_ENTER) begin
            r_cause <= w_cause;
            r_haddr <= w_vec;
         end
         // Ack is registered, so it lands in the first HANDLER cycle.
         if (r_state == S_ENTER && !if_trap.stall && r_cause[3])
            r_irq_ack <= NUM_IRQ'(1) << r_cause[2:0];
         else
            r_irq_ack <= '0;
         r_first <= (r_state == S_ENTER) && !if_trap.stall;
         if (r_state == S_HANDLER && r_first) r_epc <= if_trap.epc_in;
         if (r_state == S_HANDLER && w_sync) r_df <= 1'b1;
         if (if_trap.mask_we) r_mask <= if_trap.mask_wdata;
      end
   end

   assign if_trap.exception       = (r_state == S_ENTER);
   assign if_trap.ret_taken       = (r_state == S_RETURN);
   assign if_trap.in_handler      = (r_state != S_RUN);
   assign if_trap.handler_address = r_haddr;
   assign if_trap.ret_target      = r_epc;
   assign if_trap.cause           = r_cause;
   assign if_trap.irq_ack         = r_irq_ack;
   assign if_trap.double_fault    = r_df;
endmodule

// File: tb/tb_trap_controller.sv
// Directed + random bench for trap_controller against a cycle-level behavioural model.
module tb_trap_controller;
   localparam int AW = 19;
   localparam int NI = 4;
   localparam logic [AW-1:0] VB = 19'h7F000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   trap_if #(.ADDR_W(AW), .NUM_IRQ(NI)) bif ();
   trap_controller #(.ADDR_W(AW), .NUM_IRQ(NI), .VEC_BASE(VB)) dut (
      .clk(clk), .rst(rst), .if_trap(bif)
   );

   int errors = 0;
   int checks = 0;
   int exc_cycles;

   // Model: "trap active" plus which redirect is outstanding.
   logic          m_exc, m_ret, m_inh, m_df, m_first;
   logic [3:0]    m_cause;
   logic [AW-1:0] m_haddr, m_rtgt;
   logic [NI-1:0] m_ack, m_mask;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("exception", 32'(bif.exception), 32'(m_exc));
      chk("ret_taken", 32'(bif.ret_taken), 32'(m_ret));
      chk("in_handler", 32'(bif.in_handler), 32'(m_inh));
      chk("cause", 32'(bif.cause), 32'(m_cause));
      chk("handler_address", 32'(bif.handler_address), 32'(m_haddr));
      chk("ret_target", 32'(bif.ret_target), 32'(m_rtgt));
      chk("irq_ack", 32'(bif.irq_ack), 32'(m_ack));
      chk("double_fault", 32'(bif.double_fault), 32'(m_df));
   endtask

   task automatic model_reset();
      {m_exc, m_ret, m_inh, m_df, m_first} = '0;
      m_cause = '0; m_haddr = '0; m_rtgt = '0; m_ack = '0; m_mask = '0;
   endtask

   task automatic model_step();
      logic          sync;
      logic [NI-1:0] pend, ack;
      int            c;
      sync = bif.illegal_instr | bif.syscall | bif.arith_ovf;
      pend = bif.irq & m_mask;
      ack  = '0;
      if (!m_inh) begin
         if ((sync || pend != 0) && !bif.stall) begin
            if (bif.illegal_instr) c = 1;
            else if (bif.syscall) c = 2;
            else if (bif.arith_ovf) c = 3;
            else begin
               c = 0;
               for (int i = 0; i < NI; i++) if (c == 0 && pend[i]) c = 8 + i;
            end
            m_cause = 4'(c);
            m_haddr = AW'((int'(VB) + c * 4) % (1 << AW));
            m_exc = 1'b1;
            m_inh = 1'b1;
         end
      end else if (m_exc) begin
         if (!bif.stall) begin
            m_exc = 1'b0;
            m_first = 1'b1;
            if (m_cause >= 8) ack[m_cause - 8] = 1'b1;
         end
      end else if (m_ret) begin
         if (!bif.stall) begin
            m_ret = 1'b0;
            m_inh = 1'b0;
         end
      end else begin
         if (m_first) m_rtgt = bif.epc_in;
         m_first = 1'b0;
         if (sync) m_df = 1'b1;
         if (bif.eret && !bif.stall) m_ret = 1'b1;
      end
      m_ack = ack;
      if (bif.mask_we) m_mask = bif.mask_wdata;
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_reset(); else model_step();
      #1;
      check_all();
      if (bif.exception) exc_cycles++;
   endtask

   task automatic idle_in();
      bif.stall = 0; bif.illegal_instr = 0; bif.syscall = 0; bif.arith_ovf = 0; bif.eret = 0;
      bif.irq = '0; bif.mask_we = 0; bif.mask_wdata = '0; bif.epc_in = '0;
   endtask

   initial begin
      model_reset();
      // Reset with every input high
      rst = 0;
      bif.stall = 1; bif.illegal_instr = 1; bif.syscall = 1; bif.arith_ovf = 1; bif.eret = 1;
      bif.irq = '1; bif.mask_we = 1; bif.mask_wdata = '1; bif.epc_in = '1;
      #3 check_all();
      tick(); tick();
      idle_in();
      bif.irq = 4'b1111;
      rst = 1;
      tick(); tick(); tick();
      chk("masked_irq_no_exc", 32'(bif.exception), 32'd0);

      // Illegal instruction round trip with EPC
      idle_in();
      bif.illegal_instr = 1;
      tick();
      chk("ill_exc", 32'(bif.exception), 32'd1);
      chk("ill_vec", 32'(bif.handler_address), 32'h7F004);
      chk("ill_cause", 32'(bif.cause), 32'd1);
      chk("ill_inh", 32'(bif.in_handler), 32'd1);
      bif.illegal_instr = 0;
      tick();
      chk("ill_exc_1cyc", 32'(bif.exception), 32'd0);
      bif.epc_in = 19'h00123;
      tick();
      bif.eret = 1;
      tick();
      chk("ret_taken", 32'(bif.ret_taken), 32'd1);
      chk("ret_target", 32'(bif.ret_target), 32'h00123);
      bif.eret = 0;
      tick();
      chk("ret_done", 32'(bif.in_handler), 32'd0);

      // Priority vs irq, then irq alone
      bif.mask_we = 1; bif.mask_wdata = 4'b0001;
      tick();
      bif.mask_we = 0;
      bif.illegal_instr = 1; bif.irq = 4'b0001;
      tick();
      chk("prio_cause", 32'(bif.cause), 32'd1);
      bif.illegal_instr = 0;
      tick();
      chk("prio_no_ack", 32'(bif.irq_ack), 32'd0);
      bif.irq = '0;
      bif.eret = 1; tick();
      bif.eret = 0; tick();
      bif.irq = 4'b0001;
      tick();
      chk("irq_cause", 32'(bif.cause), 32'd8);
      chk("irq_vec", 32'(bif.handler_address), 32'h7F020);
      bif.irq = '0;
      tick();
      chk("irq_ack", 32'(bif.irq_ack), 32'd1);
      tick();
      chk("irq_ack_pulse", 32'(bif.irq_ack), 32'd0);
      bif.eret = 1; tick();
      bif.eret = 0; tick();

      // Stalled ENTER, then double fault
      exc_cycles = 0;
      bif.syscall = 1;
      tick();
      bif.syscall = 0; bif.stall = 1;
      tick(); tick(); tick();
      bif.stall = 0;
      tick();
      chk("stall_exc_cycles", 32'(exc_cycles), 32'd4);
      bif.syscall = 1;
      tick();
      chk("df_set", 32'(bif.double_fault), 32'd1);
      chk("df_no_exc", 32'(bif.exception), 32'd0);
      bif.syscall = 0;
      tick();
      chk("df_sticky", 32'(bif.double_fault), 32'd1);

      // Async reset mid-handler
      rst = 0;
      #2;
      model_reset();
      check_all();
      #1 rst = 1;
      bif.eret = 1;
      tick(); tick();
      chk("eret_after_rst", 32'(bif.ret_taken), 32'd0);

      // Random traffic
      for (int n = 0; n < 800; n++) begin
         bif.stall         = ($urandom_range(0, 9) < 3);
         bif.illegal_instr = ($urandom_range(0, 19) == 0);
         bif.syscall       = ($urandom_range(0, 19) == 0);
         bif.arith_ovf     = ($urandom_range(0, 19) == 0);
         bif.eret          = ($urandom_range(0, 3) == 0);
         bif.irq           = 4'($urandom);
         bif.mask_we       = ($urandom_range(0, 15) == 0);
         bif.mask_wdata    = 4'($urandom);
         bif.epc_in        = 19'($urandom);
         if ($urandom_range(0, 149) == 0) begin
            rst = 0;
            #1;
            model_reset();
            check_all();
            tick();
            rst = 1;
         end else begin
            tick();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/trap_controller.md
# trap_controller

Exception/interrupt control unit that drives the fetch stage's redirect interface. It prioritises synchronous faults and maskable interrupt requests, issues the `exception` pulse and `handler_address` that fetch consumes, and captures the EPC that fetch returns. On a return-from-trap instruction it issues a single redirect back to the saved EPC through fetch's `branch_taken`/`branch_target` path. It sits between decode/execute (fault sources), the interrupt lines, and the fetch stage.

## Interface
- `ADDR_W`, 19, instruction address width
- `NUM_IRQ`, 4, number of interrupt request lines (1..8)
- `VEC_BASE`, 19'h7F000, handler vector base address
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `stall`  in  1  pipeline stall; same signal fetch uses
- `illegal_instr`  in  1  illegal opcode from decode (level, held while stalled)
- `syscall`  in  1  system-call instruction from decode
- `arith_ovf`  in  1  arithmetic overflow from execute
- `eret`  in  1  return-from-trap instruction decoded
- `irq`  in  NUM_IRQ  level-sensitive interrupt requests
- `mask_we`  in  1  write strobe for interrupt enable mask
- `mask_wdata`  in  NUM_IRQ  new mask value (1 = enabled)
- `epc_in`  in  ADDR_W  EPC captured by fetch
- `exception`  out  1  trap request to fetch
- `handler_address`  out  ADDR_W  trap vector to fetch
- `ret_taken`  out  1  return redirect to fetch (OR'd into `branch_taken`)
- `ret_target`  out  ADDR_W  return address (muxed into `branch_target`)
- `cause`  out  4  cause code of most recent trap
- `in_handler`  out  1  high from trap entry until return completes
- `irq_ack`  out  NUM_IRQ  one-hot, one-cycle acknowledge of taken interrupt
- `double_fault`  out  1  sticky: sync fault seen while in handler

## Operation
- States: RUN, ENTER, HANDLER, RETURN. Reset state RUN.
- Cause codes: illegal=1, syscall=2, overflow=3, irq[i]=8+i. Priority: illegal > syscall > overflow > irq[0] > irq[1] > ... .
- Pending irq = `irq & mask`. Sync faults are never masked.
- RUN: if any sync fault or pending irq and `stall`=0 → ENTER; register `cause` and `handler_address = VEC_BASE + {cause,2'b00}`. With `stall`=1 entry is deferred (no state change). `eret` in RUN is ignored.
- ENTER: `exception`=1. Held while `stall`=1. When `stall`=0 → HANDLER; `irq_ack[i]` pulses that cycle if cause is irq i.
- HANDLER: first cycle loads `saved_epc <= epc_in`; `ret_target` reflects `saved_epc`. All new faults/irqs ignored (no nesting); any sync fault sets `double_fault`. `eret` with `stall`=0 → RETURN.
- RETURN: `ret_taken`=1, `ret_target`=saved_epc. Held while `stall`=1; when `stall`=0 → RUN.
- `in_handler` = 1 in ENTER, HANDLER, RETURN.
- Mask: `mask_we` updates mask at clock edge; same-cycle arbitration uses old mask. Mask writes accepted in any state.
- Address arithmetic is modulo 2^ADDR_W.

## Timing
- All outputs registered or decoded from state register only; no combinational input-to-output path.
- Reset values: `exception`=0, `handler_address`=0, `ret_taken`=0, `ret_target`=0, `cause`=0, `in_handler`=0, `irq_ack`=0, `double_fault`=0, mask=0 (all irqs disabled), saved_epc=0.
- Fault asserted cycle N, `stall`=0 → `exception` high in cycle N+1, for exactly one cycle if `stall` stays low.
- `exception` and `ret_taken` are never high in the same cycle.
- Minimum trap round trip: fault N, ENTER N+1, HANDLER N+2 (EPC latched), earliest `eret` N+2, `ret_taken` N+3, RUN N+4.
- `rst` low at any time (including mid-ENTER/RETURN) forces RUN and reset values immediately; in-progress trap discarded; `double_fault` cleared only by reset.

## Test plan
- Reset: hold `rst`=0, drive all inputs high → all outputs 0; release, `irq`=4'b1111 with mask 0 → no `exception`.
- `illegal_instr`=1 one cycle, `stall`=0 → `exception` 1 cycle later for 1 cycle, `handler_address`=19'h7F004, `cause`=1, `in_handler`=1.
- `illegal_instr` and `irq[0]` together, mask=4'b0001 → `cause`=1, `irq_ack`=0; write mask, `irq[0]` alone later → `cause`=8, `handler_address`=19'h7F020, `irq_ack`=4'b0001 single pulse.
- Trap entry with `epc_in`=19'h00123, then `eret` → `ret_taken` one cycle, `ret_target`=19'h00123, `in_handler` drops next cycle.
- `stall`=1 for 3 cycles during ENTER → `exception` high 4 cycles total, then HANDLER; `syscall` during HANDLER → `double_fault`=1 sticky, no new `exception`.
- `rst` pulsed low during HANDLER → RUN, all outputs 0, subsequent `eret` produces no `ret_taken`.
